// File: rtl/apb_modport_if.sv
// rtl/apb_modport_if.sv - APB bus bundle with master, slave and monitor modports
interface apb_modport_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NO_OF_SLAVES = 7
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic                    pwrite;
    logic [NO_OF_SLAVES-1:0] psel_x;
    logic                    penable;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel_x, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel_x, penable,
        output prdata, pready, pslverr
    );

    modport monitor (
        input paddr, pwdata, pwrite, psel_x, penable,
        input prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_modport.sv
// rtl/apb_modport.sv - APB completer array of one-hot selected register banks
module apb_modport #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NO_OF_SLAVES   = 7,
    parameter int REGS_PER_SLAVE = 8
) (
    input  logic          pclock,
    input  logic          presetn,   // active-high asynchronous reset despite the name
    apb_modport_if.slave  bus
);
    // The last register of every bank is the read-only ID, so only the
    // lower REGS_PER_SLAVE-1 registers need storage.
    localparam int DATA_REGS = REGS_PER_SLAVE - 1;
    localparam int IDX_W     = $clog2(REGS_PER_SLAVE);
    localparam int BANK_W    = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam int CNT_W     = $clog2(NO_OF_SLAVES + 1);
    localparam int WIN_LSB   = IDX_W + 2;
    localparam logic [15:0] ID_TAG = 16'hA9B0;

    logic [DATA_WIDTH-1:0] regs_q [NO_OF_SLAVES][DATA_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NO_OF_SLAVES][DATA_REGS];

    logic [CNT_W-1:0]      sel_count;
    logic [BANK_W-1:0]     bank;
    logic [IDX_W-1:0]      reg_idx;
    logic                  sel_any;
    logic                  sel_onehot;
    logic                  access;
    logic                  misaligned;
    logic                  out_of_window;
    logic                  ro_write;
    logic                  xfer_err;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;

    // Count asserted selects and remember which bank is addressed; the bank
    // number is only meaningful when exactly one select is high.
    always_comb begin
        sel_count = '0;
        bank      = '0;
        for (int k = 0; k < NO_OF_SLAVES; k++) begin
            if (bus.psel_x[k]) begin
                sel_count = sel_count + CNT_W'(1);
                bank      = BANK_W'(k);
            end
        end
    end

    assign sel_any       = (sel_count != '0);
    assign sel_onehot    = (sel_count == CNT_W'(1));
    assign reg_idx       = bus.paddr[WIN_LSB-1:2];
    assign misaligned    = |bus.paddr[1:0];
    assign out_of_window = |bus.paddr[ADDR_WIDTH-1:WIN_LSB];
    assign ro_write      = bus.pwrite && (reg_idx == IDX_W'(DATA_REGS));

    // Any select with penable is an access phase; penable without a select
    // is simply ignored and never reports an error.
    assign access   = sel_any && bus.penable;
    assign xfer_err = !sel_onehot || misaligned || out_of_window || ro_write;
    assign wr_en    = access && bus.pwrite && !xfer_err;
    assign rd_en    = access && !bus.pwrite && !xfer_err;

    // Read mux: the ID word for the top index, otherwise the stored register.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NO_OF_SLAVES; k++) begin
            if (bank == BANK_W'(k)) begin
                if (reg_idx == IDX_W'(DATA_REGS)) begin
                    rd_word = DATA_WIDTH'({ID_TAG, 8'h00, 8'(k)});
                end else begin
                    for (int r = 0; r < DATA_REGS; r++) begin
                        if (reg_idx == IDX_W'(r)) begin
                            rd_word = regs_q[k][r];
                        end
                    end
                end
            end
        end
    end

    // Next-state of the register file: only the addressed word of the
    // addressed bank takes the full write data.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            for (int k = 0; k < NO_OF_SLAVES; k++) begin
                for (int r = 0; r < DATA_REGS; r++) begin
                    if ((bank == BANK_W'(k)) && (reg_idx == IDX_W'(r))) begin
                        regs_d[k][r] = bus.pwdata;
                    end
                end
            end
        end
    end

    // Register file storage; reset discards any access in flight.
    always_ff @(posedge pclock or posedge presetn) begin
        if (presetn) begin
            for (int k = 0; k < NO_OF_SLAVES; k++) begin
                for (int r = 0; r < DATA_REGS; r++) begin
                    regs_q[k][r] <= '0;
                end
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Zero-wait-state response, held quiet while reset is asserted.
    assign bus.pready  = access && !presetn;
    assign bus.pslverr = access && xfer_err && !presetn;
    assign bus.prdata  = (rd_en && !presetn) ? rd_word : '0;
endmodule

// File: tb/tb_apb_modport.sv
// tb/tb_apb_modport.sv - self-checking bench for apb_modport
module tb_apb_modport;
    logic pclock;
    logic presetn;

    apb_modport_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NO_OF_SLAVES(7)) bus ();

    apb_modport #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NO_OF_SLAVES(7), .REGS_PER_SLAVE(8)
    ) dut (
        .pclock  (pclock),
        .presetn (presetn),
        .bus     (bus.slave)
    );

    initial pclock = 1'b0;
    always #5 pclock = ~pclock;

    typedef struct {
        logic        rdy;
        logic        err;
        logic [31:0] rdata;
        string       tag;
    } exp_t;

    typedef struct {
        logic [6:0]  sel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[$];
    logic [31:0] mdl [7][8];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sample_access();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            checks--;
            e = sb.pop_front();
            check({e.tag, " pready"},  32'(bus.pready),  32'(e.rdy));
            check({e.tag, " pslverr"}, 32'(bus.pslverr), 32'(e.err));
            check({e.tag, " prdata"},  bus.prdata,       e.rdata);
        end
    endtask

    // One setup + access transfer; callers start just after a rising edge.
    task automatic xfer(input logic [6:0] sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata, input string tag);
        exp_t e;
        bus.psel_x  = sel;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        bus.penable = 1'b0;
        @(negedge pclock);
        check({tag, " setup pready"}, 32'(bus.pready), 32'd0);
        @(posedge pclock); #1;
        bus.penable = 1'b1;
        e.rdy = 1'b1; e.err = exp_err; e.rdata = exp_rdata; e.tag = tag;
        sb.push_back(e);
        @(negedge pclock);
        sample_access();
        @(posedge pclock); #1;
        bus.psel_x  = '0;
        bus.penable = 1'b0;
    endtask

    task automatic wr_reg(input int k, input int r, input logic [31:0] d);
        xfer(7'(1) << k, 1'b1, 32'(r * 4), d, 1'b0, 32'd0, $sformatf("wr b%0d r%0d", k, r));
        mdl[k][r] = d;
    endtask

    task automatic rd_reg(input int k, input int r);
        logic [31:0] exp;
        exp = (r == 7) ? (32'hA9B0_0000 | 32'(k)) : mdl[k][r];
        xfer(7'(1) << k, 1'b0, 32'(r * 4), 32'd0, 1'b0, exp, $sformatf("rd b%0d r%0d", k, r));
    endtask

    task automatic clear_model();
        for (int k = 0; k < 7; k++)
            for (int r = 0; r < 8; r++)
                mdl[k][r] = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        clear_model();
        vt.push_back('{7'b0100000, 1'b0, 32'h1C, 32'h0,        1'b0, 32'hA9B0_0005});
        vt.push_back('{7'b0100000, 1'b1, 32'h1C, 32'h12345678, 1'b1, 32'h0});
        vt.push_back('{7'b0100000, 1'b0, 32'h1C, 32'h0,        1'b0, 32'hA9B0_0005});
        vt.push_back('{7'b0001000, 1'b1, 32'h02, 32'h0BAD0BAD, 1'b1, 32'h0});
        vt.push_back('{7'b0001000, 1'b1, 32'h20, 32'h0BAD0BAD, 1'b1, 32'h0});
        vt.push_back('{7'b0001000, 1'b0, 32'h22, 32'h0,        1'b1, 32'h0});
        vt.push_back('{7'b0000011, 1'b1, 32'h04, 32'hFFFFFFFF, 1'b1, 32'h0});
        vt.push_back('{7'b0000001, 1'b0, 32'h04, 32'h0,        1'b0, 32'h1000_0001});
        vt.push_back('{7'b0000010, 1'b0, 32'h04, 32'h0,        1'b0, 32'h1000_0011});
        vt.push_back('{7'b0001000, 1'b0, 32'h00, 32'h0,        1'b0, 32'h1000_0030});
        vt.push_back('{7'b0000001, 1'b0, 32'h1C, 32'h0,        1'b0, 32'hA9B0_0000});
        vt.push_back('{7'b1111111, 1'b0, 32'h00, 32'h0,        1'b1, 32'h0});
        vt.push_back('{7'b1000000, 1'b0, 32'h40, 32'h0,        1'b1, 32'h0});

        bus.psel_x = '0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0;
        presetn = 1'b1;
        repeat (2) @(posedge pclock);
        #1 presetn = 1'b0;

        // reset mid-write discards the transfer and clears the banks
        wr_reg(2, 0, 32'h0000_0055);
        rd_reg(2, 0);
        bus.psel_x = 7'b0000100; bus.pwrite = 1'b1; bus.paddr = 32'h0;
        bus.pwdata = 32'hDEADBEEF; bus.penable = 1'b0;
        @(posedge pclock); #1;
        bus.penable = 1'b1;
        presetn = 1'b1;
        @(negedge pclock);
        check("reset pready",  32'(bus.pready),  32'd0);
        check("reset pslverr", 32'(bus.pslverr), 32'd0);
        check("reset prdata",  bus.prdata,       32'd0);
        @(posedge pclock); #1;
        bus.psel_x = '0; bus.penable = 1'b0;
        presetn = 1'b0;
        clear_model();
        rd_reg(2, 0);

        // write then read back every data register of every bank
        for (int k = 0; k < 7; k++)
            for (int r = 0; r < 7; r++)
                wr_reg(k, r, 32'h1000_0000 + 32'(k * 16 + r));
        for (int k = 0; k < 7; k++)
            for (int r = 0; r < 7; r++)
                rd_reg(k, r);

        // table-driven error and ID cases
        for (int i = 0; i < vt.size(); i++)
            xfer(vt[i].sel, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].err, vt[i].rdata,
                 $sformatf("vec%0d", i));

        // penable without select is ignored
        bus.psel_x = '0; bus.penable = 1'b1; bus.pwrite = 1'b1;
        bus.paddr = 32'h0; bus.pwdata = 32'h5A5A5A5A;
        @(negedge pclock);
        check("nosel pready",  32'(bus.pready),  32'd0);
        check("nosel pslverr", 32'(bus.pslverr), 32'd0);
        @(posedge pclock); #1;
        bus.penable = 1'b0;

        // back-to-back write then read of the same register
        wr_reg(6, 3, 32'hCAFEF00D);
        rd_reg(6, 3);

        // no stray writes anywhere, ID registers intact
        for (int k = 0; k < 7; k++)
            for (int r = 0; r < 8; r++)
                rd_reg(k, r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
